// File: rtl/knips_pkg.sv
// Shared types and widths for the KNIPS program-counter sequencer.
package knips_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} seq_state_t;

  localparam int LUT_IDX_W = 4;
  localparam int TARGET_W  = 16;
  localparam int CYC_W     = 16;
endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for the RUN state.
// Owns the branch-target mode: with BRANCH_REL_EN defined the LUT value is a
// two's-complement offset from the current PC, otherwise an absolute address.
module next_pc_calc
  import knips_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0]     pc_i,
  input  logic [PC_W-1:0]     link_i,
  input  logic [TARGET_W-1:0] target_i,
  input  logic                stall_i,
  input  logic                halt_i,
  input  logic                ret_i,
  input  logic                jal_i,
  input  logic                br_i,
  output logic [PC_W-1:0]     next_pc_o,
  output logic                link_we_o
);

  logic [PC_W-1:0] tgt;

  // Upper LUT bits beyond the PC width carry no meaning for this core.
  if (PC_W < TARGET_W) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^target_i[TARGET_W-1:PC_W];
  end

  // Resolve the effective transfer target (wraps modulo 2^PC_W).
  always_comb begin
`ifdef BRANCH_REL_EN
    tgt = pc_i + target_i[PC_W-1:0];
`else
    tgt = target_i[PC_W-1:0];
`endif
  end

  // Priority: stall/halt hold, then Ret, Jal, BranchTaken, then increment.
  always_comb begin
    next_pc_o = pc_i + 1'b1;
    link_we_o = 1'b0;
    if (stall_i || halt_i) begin
      next_pc_o = pc_i;
    end else if (ret_i) begin
      next_pc_o = link_i;
    end else if (jal_i) begin
      next_pc_o = tgt;
      link_we_o = 1'b1;
    end else if (br_i) begin
      next_pc_o = tgt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/RUN/HALT program-counter sequencer for the KNIPS core.
// Drives the external branch-target LUT index, keeps a single-entry link
// register and a saturating run-cycle counter.
// Optional feature macro: BRANCH_REL_EN (PC-relative branch targets).
module pc_sequencer
  import knips_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int START_PC = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 BranchTaken,
  input  logic                 Jal,
  input  logic                 Ret,
  input  logic [LUT_IDX_W-1:0] BranchIdx,
  output logic [LUT_IDX_W-1:0] LutIdx,
  input  logic [TARGET_W-1:0]  Target,
  output logic [PC_W-1:0]      ProgCtr,
  output logic                 Done,
  output logic [CYC_W-1:0]     CycleCnt
);

  localparam logic [PC_W-1:0] START_VAL = PC_W'(START_PC);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  link_q, link_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  run_pc;
  logic             run_link_we;

  assign LutIdx   = BranchIdx;
  assign ProgCtr  = pc_q;
  assign Done     = (state_q == HALT);
  assign CycleCnt = cnt_q;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc_i      (pc_q),
    .link_i    (link_q),
    .target_i  (Target),
    .stall_i   (Stall),
    .halt_i    (Halt),
    .ret_i     (Ret),
    .jal_i     (Jal),
    .br_i      (BranchTaken),
    .next_pc_o (run_pc),
    .link_we_o (run_link_we)
  );

  // Next-state: Start restarts from IDLE/HALT; RUN advances the PC and counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    link_d  = link_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_VAL;
          link_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Stalled cycles still count as run time.
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        pc_d = run_pc;
        if (run_link_we) link_d = pc_q + 1'b1;
        if (Halt && !Stall) state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_VAL;
      link_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed stimulus, a behavioural model checked every
// cycle, and literal expectations at key points of the sequence.
module tb_pc_sequencer;

  localparam int PC_W = 10;
  localparam int MASK = (1 << PC_W) - 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1, Start = 1'b0, Stall = 1'b0, Halt = 1'b0;
  logic        BranchTaken = 1'b0, Jal = 1'b0, Ret = 1'b0;
  logic [3:0]  BranchIdx = 4'd0;
  logic [3:0]  LutIdx;
  logic [15:0] Target;
  logic [PC_W-1:0] ProgCtr;
  logic        Done;
  logic [15:0] CycleCnt;

  logic [15:0] lut [16];
  int total = 0, bad = 0;
  bit chk_en = 0;

  // model state
  bit m_run = 0, m_halted = 0;
  int m_pc = 0, m_link = 0, m_cnt = 0;

  always #5 Clk = ~Clk;

  assign Target = lut[LutIdx];

  pc_sequencer #(.PC_W(PC_W), .START_PC(0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchTaken(BranchTaken), .Jal(Jal), .Ret(Ret), .BranchIdx(BranchIdx),
    .LutIdx(LutIdx), .Target(Target), .ProgCtr(ProgCtr), .Done(Done),
    .CycleCnt(CycleCnt)
  );

  function automatic int tgt_of(int pc, int idx);
    int v;
    v = (idx >= 13) ? 0 : int'(lut[idx]);
`ifdef BRANCH_REL_EN
    return (pc + v) & MASK;
`else
    return v & MASK;
`endif
  endfunction

  // Model: advance on each rising edge from the sampled inputs.
  always @(posedge Clk) begin
    if (Reset) begin
      m_run = 0; m_halted = 0; m_pc = 0; m_link = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (Start) begin
        m_run = 1; m_halted = 0; m_pc = 0; m_link = 0; m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!Stall) begin
        if (Halt) begin
          m_run = 0; m_halted = 1;
        end else if (Ret) m_pc = m_link;
        else if (Jal) begin
          m_link = (m_pc + 1) & MASK;
          m_pc = tgt_of(m_pc, int'(BranchIdx));
        end else if (BranchTaken) m_pc = tgt_of(m_pc, int'(BranchIdx));
        else m_pc = (m_pc + 1) & MASK;
      end
    end
  end

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("model_pc",   int'(ProgCtr),  m_pc);
      check("model_done", int'(Done),     int'(m_halted));
      check("model_cnt",  int'(CycleCnt), m_cnt);
      check("model_lut",  int'(LutIdx),   int'(BranchIdx));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut[i] = 16'd0;
    lut[2] = 16'd32;
    lut[3] = 16'd61;
    lut[4] = 16'd20;
    lut[5] = 16'hFFFF;
    lut[8] = 16'd40;
    lut[13] = 16'h1234; // indices 13-15 must still read as 0 via the LUT model
    lut[13] = 16'd0;

    // Reset
    tick(); chk_en = 1; tick();
    check("rst_pc", int'(ProgCtr), 0);
    check("rst_done", int'(Done), 0);
    check("rst_cnt", int'(CycleCnt), 0);

    // Start, then 5 plain cycles
    Reset = 0; Start = 1; tick(); Start = 0;
    check("start_pc", int'(ProgCtr), 0);
    repeat (5) tick();
    check("seq_pc5", int'(ProgCtr), 5);
    check("seq_cnt5", int'(CycleCnt), 5);
    check("seq_done", int'(Done), 0);

    // Branch at PC=7 via index 3
    repeat (2) tick();
    check("pc7", int'(ProgCtr), 7);
    BranchTaken = 1; BranchIdx = 4'd3; #1;
    check("lutidx3", int'(LutIdx), 3);
    tick();
`ifdef BRANCH_REL_EN
    check("br_rel", int'(ProgCtr), 68);
    BranchIdx = 4'd5; tick(); // offset -1
    check("br_rel_neg", int'(ProgCtr), 67);
`else
    check("br_abs", int'(ProgCtr), 61);
    BranchIdx = 4'd5; tick(); // truncated to 1023
    check("br_trunc", int'(ProgCtr), 1023);
    BranchTaken = 0; tick();
    check("pc_wrap", int'(ProgCtr), 0);
    BranchTaken = 1; BranchIdx = 4'd4; tick();
    check("br_20", int'(ProgCtr), 20);
`endif
    // Jal, then Ret stalled, then Ret
    BranchTaken = 0; Jal = 1; BranchIdx = 4'd2; tick();
`ifndef BRANCH_REL_EN
    check("jal_pc", int'(ProgCtr), 32);
`endif
    Jal = 0; Ret = 1; Stall = 1; tick(); tick();
`ifndef BRANCH_REL_EN
    check("ret_stall", int'(ProgCtr), 32);
`endif
    Stall = 0; tick();
`ifndef BRANCH_REL_EN
    check("ret_pc", int'(ProgCtr), 21);
`endif
    Ret = 0;

    // Halt with Stall for 3 cycles, halt also beats Jal
    Halt = 1; Jal = 1; Stall = 1;
    repeat (3) tick();
    check("halt_stall_done", int'(Done), 0);
    Stall = 0; tick();
    check("halt_done", int'(Done), 1);
`ifndef BRANCH_REL_EN
    check("halt_pc", int'(ProgCtr), 21);
`endif
    Halt = 0; Jal = 0; BranchTaken = 1; tick(); tick();
    check("halt_hold_done", int'(Done), 1);
    BranchTaken = 0;

    // Restart from HALT
    Start = 1; tick(); Start = 0;
    check("restart_pc", int'(ProgCtr), 0);
    check("restart_cnt", int'(CycleCnt), 0);
    check("restart_done", int'(Done), 0);

    // Ret with no prior Jal goes to 0; Start in RUN ignored
    repeat (2) tick();
    Ret = 1; tick(); Ret = 0;
    check("ret_nolink", int'(ProgCtr), 0);
    tick(); tick();
    Start = 1; tick(); Start = 0;
    check("start_in_run", int'(ProgCtr), 3);

    // Reset mid-RUN at PC=40 together with a taken branch
`ifndef BRANCH_REL_EN
    BranchTaken = 1; BranchIdx = 4'd8; tick();
    check("pc40", int'(ProgCtr), 40);
`endif
    Reset = 1; tick();
    check("rst_run_pc", int'(ProgCtr), 0);
    check("rst_run_cnt", int'(CycleCnt), 0);
    check("rst_run_done", int'(Done), 0);
    Reset = 0; Jal = 1; tick(); tick();
    check("idle_ignore_pc", int'(ProgCtr), 0);
    check("idle_ignore_cnt", int'(CycleCnt), 0);
    BranchTaken = 0; Jal = 0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
